// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave front end: command codes, phy state
// encoding and the fixed SPI word width.
package spi_pkg;

  localparam int SPI_WORD_W = 8;

  localparam logic [3:0] CMD_NOP  = 4'd0;
  localparam logic [3:0] CMD_FIFO = 4'd1;
  localparam logic [3:0] CMD_RD   = 4'd2;
  localparam logic [3:0] CMD_WR   = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CMD_BYTE = 2'd1,
    ST_DATA     = 2'd2
  } phy_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for one asynchronous input, with one-clock rise/fall
// strobes derived from the synchronised level.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/spi_slave_phy.sv
// SPI mode-0 slave front end: oversampled SCK/MOSI/CS_N, MSB-first byte
// deserialiser, command-nibble decode and MISO serialiser.
module spi_slave_phy
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WORD_W      = SPI_WORD_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       mosi,
  input  logic       cs_n,
  output logic       miso,
  output logic       miso_oe,
  output logic [3:0] CMD,
  output logic       cmd_valid,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       DONE,
  input  logic [7:0] tx_data,
  output logic       tx_ack
);

  logic sck_lvl, sck_rise, sck_fall;
  logic mosi_sync, mosi_rise, mosi_fall;
  logic cs_sync, cs_rise, cs_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk_i(clk), .rst_i(rst), .d_i(sck),
    .q_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk_i(clk), .rst_i(rst), .d_i(mosi),
    .q_o(mosi_sync), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk_i(clk), .rst_i(rst), .d_i(cs_n),
    .q_o(cs_sync), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  // SCK level and MOSI edges carry no information here; only SCK edges and the MOSI level do.
  logic unused_sync_outs;
  assign unused_sync_outs = ^{sck_lvl, mosi_rise, mosi_fall};

  phy_state_e        state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] rx_shift_q, rx_shift_d;
  logic [WORD_W-1:0] tx_shift_q, tx_shift_d;
  logic              skip_fall_q, skip_fall_d;
  logic [3:0]        cmd_q, cmd_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              tx_ack_q, tx_ack_d;
  logic              miso_oe_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    skip_fall_d = skip_fall_q;
    cmd_d       = cmd_q;
    cmd_valid_d = cmd_valid_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_ack_d    = 1'b0;

    // Deselect outranks everything, including a coincident SCK edge.
    if (cs_rise) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = 3'd0;
      rx_shift_d  = '0;
      skip_fall_d = 1'b0;
      cmd_d       = CMD_NOP;
      cmd_valid_d = 1'b0;
    end else if (cs_fall) begin
      state_d     = ST_CMD_BYTE;
      bit_cnt_d   = 3'd0;
      rx_shift_d  = '0;
      tx_shift_d  = '0;
      skip_fall_d = 1'b0;
      cmd_d       = CMD_NOP;
      cmd_valid_d = 1'b0;
    end else if (state_q != ST_IDLE) begin
      if (sck_rise) begin
        rx_shift_d = {rx_shift_q[WORD_W-2:0], mosi_sync};
        bit_cnt_d  = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'(SPI_WORD_W - 1)) begin
          tx_shift_d  = tx_data;
          tx_ack_d    = 1'b1;
          skip_fall_d = 1'b1;
          if (state_q == ST_CMD_BYTE) begin
            cmd_d       = rx_shift_d[3:0];
            cmd_valid_d = 1'b1;
            state_d     = ST_DATA;
          end else begin
            rx_data_d  = rx_shift_d;
            rx_valid_d = 1'b1;
          end
        end
      end else if (sck_fall) begin
        // The fall right after a load must leave the new MSB on MISO.
        if (skip_fall_q) begin
          skip_fall_d = 1'b0;
        end else begin
          tx_shift_d = {tx_shift_q[WORD_W-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      skip_fall_q <= 1'b0;
      cmd_q       <= CMD_NOP;
      cmd_valid_q <= 1'b0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      tx_ack_q    <= 1'b0;
      miso_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      skip_fall_q <= skip_fall_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_ack_q    <= tx_ack_d;
      miso_oe_q   <= ~cs_sync;
    end
  end

  assign miso      = tx_shift_q[WORD_W-1];
  assign miso_oe   = miso_oe_q;
  assign CMD       = cmd_q;
  assign cmd_valid = cmd_valid_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign DONE      = rx_valid_q;
  assign tx_ack    = tx_ack_q;

endmodule

// File: doc/spi_slave_phy.md
Name: spi_slave_phy

Overview:
Serial front end of the SPI slave on the CycloneIII, directly upstream of the SPI command state machine. Oversamples the external master's SCK/MOSI/CS_N in the system clock domain and deserialises bytes MSB first in SPI mode 0. Decodes the first byte of each frame into the 4-bit CMD bus and pulses DONE once per completed data byte. Serialises tx_data onto MISO for read and FIFO transfers.

Parameters:
SYNC_STAGES, 2, flip-flop stages on each of sck/mosi/cs_n (legal 2..3)
WORD_W, 8, bits per SPI byte; only 8 is supported, bit counter is 3 bits

Ports:
clk        in   1  system clock; must be >= 8x SCK frequency
rst        in   1  asynchronous reset, active-high
sck        in   1  SPI clock from master, async
mosi       in   1  master-out data, async
cs_n       in   1  chip select, active-low, async
miso       out  1  slave-out data
miso_oe    out  1  MISO output enable (tri-state control at top level)
CMD        out  4  decoded command nibble, held for the whole frame
cmd_valid  out  1  high from command byte completion until frame end
rx_data    out  8  last received data byte
rx_valid   out  1  one-clk pulse, rx_data updated
DONE       out  1  one-clk pulse per completed data byte (same cycle as rx_valid)
tx_data    in   8  next byte to transmit; sampled on tx_ack
tx_ack     out  1  one-clk pulse when tx_data is loaded into the shifter

Behaviour:
- Reset (async, rst=1): sync chains to sck=0, mosi=0, cs_n=1; state IDLE; bit_cnt=0; shift regs=0; CMD=0, cmd_valid=0, rx_data=0, rx_valid=0, DONE=0, tx_ack=0, miso=0, miso_oe=0.
- Edge detect on the synchronised signals: sck_rise, sck_fall, cs_fall, cs_rise, each one clk wide.
- miso_oe = ~cs_n_sync (registered). miso = tx_shift[7].
- States:
  IDLE: on cs_fall -> CMD_BYTE; bit_cnt=0; tx_shift=0x00, so MISO sends zeros during the command byte.
  CMD_BYTE: on sck_rise, rx_shift = {rx_shift[6:0], mosi_sync} and bit_cnt++. On the 8th rise (bit_cnt 7->0):
    - CMD = byte[3:0], with the upper nibble ignored.
    - cmd_valid=1.
    - tx_shift=tx_data, tx_ack pulse.
    - -> DATA.
  DATA: the same shift applies. On each 8th rise:
    - rx_data = byte; rx_valid and DONE pulse.
    - tx_shift=tx_data, tx_ack pulse.
    - Stay in DATA.
  On sck_fall (CMD_BYTE/DATA), tx_shift shifts left with 0 in, except on the fall directly after a load.
- cs_rise in any state -> IDLE. Effects:
  - Partial byte discarded, with no DONE or rx_valid.
  - bit_cnt=0; CMD=0, cmd_valid=0.
  - tx_ack suppressed.
- cs_rise coincident with sck_rise: cs wins, the edge is ignored and no byte completes.
- cs_fall while not in IDLE (glitch re-select) restarts the frame in CMD_BYTE.
- Latency: DONE rises 3 clk (SYNC_STAGES+1) after the 8th SCK rising edge at the pin.
- Command codes: NOP=0, FIFO=1, RD=2, WR=3. Other codes are passed through unchanged; the downstream state machine treats them as NOP.
- DONE pulses never occur for the command byte. A frame with only a command byte yields cmd_valid but no DONE.

Decomposition:
- Package spi_pkg holds:
  - CMD_NOP/CMD_FIFO/CMD_RD/CMD_WR (4-bit localparams).
  - Phy state encoding (IDLE, CMD_BYTE, DATA).
  - SPI_WORD_W=8.
- One sub-module, spi_sync_edge: an N-stage synchroniser plus rise/fall detector with configurable reset value. It is instantiated three times (sck, mosi, cs_n); for mosi, the edge outputs are unused.

Test Plan:
1. cs_n low, shift 0x02, cs_n high -> CMD=2 and cmd_valid=1 from 3 clk after the 8th edge; no DONE; after cs_rise, CMD=0 and cmd_valid=0.
2. Frame 0x03,0x5A,0xC3 with tx_data=0x96 -> two DONE/rx_valid pulses with rx_data 0x5A then 0xC3; master receives 0x00,0x96,0x96 on MISO; tx_ack pulses 3 times.
3. Command 0x01 then 4 data bytes, tx_data stepping 0x10..0x13 on each tx_ack -> MISO bytes 0x00,0x10,0x11,0x12,0x13; 4 DONE pulses.
4. 0x02 followed by only 5 SCK edges, then cs_n high -> no DONE; state IDLE; bit_cnt=0. The next frame 0x03 decodes correctly.
5. Assert rst mid data byte -> all outputs go to reset values asynchronously (before the next clk edge). After release, frame 0x02,0xFF -> CMD=2 and one DONE with rx_data=0xFF.
6. cs_n deasserted in the same clk as the 8th synchronised SCK rise -> no DONE, no rx_data update, CMD cleared.
